// File: rtl/pixel_stream_framer_pkg.sv
// Shared definitions for the pixel stream framer: FSM encoding, FIFO entry layout
// and the default buffer depth.
package pixel_stream_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int DEPTH_DEFAULT = 16;

    // Entry layout, MSB first: {sof, eol, eof, rgb[23:0]}
    localparam int RGB_W   = 24;
    localparam int RGB_LSB = 0;
    localparam int EOF_BIT = 24;
    localparam int EOL_BIT = 25;
    localparam int SOF_BIT = 26;
    localparam int ENTRY_W = 27;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic             sof,
        input logic             eol,
        input logic             eof,
        input logic [RGB_W-1:0] rgb
    );
        return {sof, eol, eof, rgb};
    endfunction

endpackage

// File: rtl/pixel_stream_framer_if.sv
// Pixel handshake bundle: upstream pixels in, tagged pixels out to the display side.
interface pixel_stream_framer_if;
    import pixel_stream_framer_pkg::*;

    logic [RGB_W-1:0] in_rgb;
    logic             in_valid;
    logic             in_ready;
    logic [RGB_W-1:0] out_rgb;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;

    modport master (
        output in_rgb, in_valid, out_ready,
        input  in_ready, out_rgb, out_valid, out_sof, out_eol, out_eof
    );

    modport slave (
        input  in_rgb, in_valid, out_ready,
        output in_ready, out_rgb, out_valid, out_sof, out_eol, out_eof
    );

endinterface

// File: rtl/pixel_stream_framer_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is presented whenever not empty.
module sync_fwft_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    // Overflow and underflow are refused here as a second line of defence.
    assign push_s  = wr_en && (count_r != FULL_COUNT);
    assign pop_s   = rd_en && (count_r != CNT_ZERO);
    assign empty   = (count_r == CNT_ZERO);
    assign count   = count_r;
    assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array, no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_framer.sv
// Tags an incoming pixel stream with sof/eol/eof using frame dimensions latched at
// frame start, and buffers tagged pixels towards the display driver.
module pixel_stream_framer
    import pixel_stream_framer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DIM_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    pixel_stream_framer_if.slave   bus,
    input  logic [DIM_W-1:0]       frame_width,
    input  logic [DIM_W-1:0]       frame_height,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1'b1);
    localparam logic [DIM_W-1:0]  DIM_ZERO   = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0]  DIM_ONE    = DIM_W'(1'b1);

    state_t              state_r, state_next_s;
    logic [DIM_W-1:0]    w_r, h_r, x_r, y_r;
    logic [DIM_W-1:0]    w_next_s, h_next_s, x_next_s, y_next_s;
    logic [DIM_W-1:0]    cur_w_s, cur_h_s, cur_x_s, cur_y_s;
    logic                sof_s, eol_s, eof_s;
    logic                accept_s, pop_s;
    logic                in_ready_r, in_ready_next_s;
    logic                frame_done_r, frame_done_next_s;
    logic                busy_r;
    logic [ENTRY_W-1:0]  wr_entry_s, rd_entry_s;
    logic                fifo_empty_s;
    logic [FILL_W-1:0]   count_s, count_next_s;

    assign accept_s   = bus.in_valid && in_ready_r;
    assign pop_s      = bus.out_ready && !fifo_empty_s;
    assign wr_entry_s = pack_entry(sof_s, eol_s, eof_s, bus.in_rgb);

    sync_fwft_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_s),
        .wr_data (wr_entry_s),
        .rd_en   (pop_s),
        .rd_data (rd_entry_s),
        .empty   (fifo_empty_s),
        .count   (count_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.out_rgb   = rd_entry_s[RGB_LSB +: RGB_W];
    assign bus.out_sof   = rd_entry_s[SOF_BIT];
    assign bus.out_eol   = rd_entry_s[EOL_BIT];
    assign bus.out_eof   = rd_entry_s[EOF_BIT];
    assign fill_level    = count_s;
    assign frame_done    = frame_done_r;
    assign busy          = busy_r;

    // Position and tags of the pixel offered this cycle; in IDLE it opens a new frame.
    always_comb begin
        cur_w_s = w_r;
        cur_h_s = h_r;
        cur_x_s = x_r;
        cur_y_s = y_r;
        if (state_r == ST_IDLE) begin
            cur_w_s = (frame_width  == DIM_ZERO) ? DIM_ONE : frame_width;
            cur_h_s = (frame_height == DIM_ZERO) ? DIM_ONE : frame_height;
            cur_x_s = DIM_ZERO;
            cur_y_s = DIM_ZERO;
        end else begin
            cur_w_s = w_r;
            cur_h_s = h_r;
        end
        sof_s = (state_r == ST_IDLE);
        eol_s = (cur_x_s == (cur_w_s - DIM_ONE));
        eof_s = eol_s && (cur_y_s == (cur_h_s - DIM_ONE));
    end

    // Next state, raster counters, occupancy and handshake outputs.
    always_comb begin
        state_next_s      = state_r;
        w_next_s          = w_r;
        h_next_s          = h_r;
        x_next_s          = x_r;
        y_next_s          = y_r;
        frame_done_next_s = 1'b0;
        count_next_s      = count_s;
        case (state_r)
            ST_IDLE, ST_ACTIVE: begin
                if (accept_s) begin
                    w_next_s = cur_w_s;
                    h_next_s = cur_h_s;
                    if (eol_s) begin
                        x_next_s = DIM_ZERO;
                        y_next_s = cur_y_s + DIM_ONE;
                    end else begin
                        x_next_s = cur_x_s + DIM_ONE;
                        y_next_s = cur_y_s;
                    end
                    state_next_s = eof_s ? ST_DRAIN : ST_ACTIVE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRAIN: begin
                // The eof entry is the last one queued, so its pop ends the frame.
                if (pop_s && rd_entry_s[EOF_BIT]) begin
                    state_next_s      = ST_IDLE;
                    frame_done_next_s = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_s + FILL_ONE;
            2'b01:   count_next_s = count_s - FILL_ONE;
            default: count_next_s = count_s;
        endcase
        in_ready_next_s = (state_next_s != ST_DRAIN) && (count_next_s != FULL_LEVEL);
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            w_r          <= DIM_ZERO;
            h_r          <= DIM_ZERO;
            x_r          <= DIM_ZERO;
            y_r          <= DIM_ZERO;
            in_ready_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            w_r          <= w_next_s;
            h_r          <= h_next_s;
            x_r          <= x_next_s;
            y_r          <= y_next_s;
            in_ready_r   <= in_ready_next_s;
            frame_done_r <= frame_done_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Randomized self-checking bench for pixel_stream_framer with a queue-based reference model.
module tb_pixel_stream_framer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic [4:0]  fill_level;
    logic        frame_done;
    logic        busy;
    int          pass_cnt;
    int          total_cnt;

    pixel_stream_framer_if bus();

    pixel_stream_framer #(.DEPTH(DEPTH), .DIM_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .fill_level   (fill_level),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one cycle from a negedge: handshakes are judged on the values before the edge.
    task automatic cycle(input logic v, input logic [23:0] rgb, input logic r,
                         output logic acc, output logic pop, output logic [26:0] popped);
        bus.in_valid  = v;
        bus.in_rgb    = rgb;
        bus.out_ready = r;
        acc    = v && (bus.in_ready === 1'b1);
        pop    = r && (bus.out_valid === 1'b1);
        popped = {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_rgb = 24'h0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd0) $display("FAIL reset_fill: got %0d want 0", fill_level); else pass_cnt++;
        total_cnt++; if ({busy, frame_done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, frame_done}); else pass_cnt++;
        total_cnt++;
        if ({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb} !== 27'h0)
            $display("FAIL reset_out_data: got %h want 0", {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb});
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    // Streams nframes frames; optionally rewrites frame_width after chg_at accepts.
    task automatic test_stream(input int w, input int h, input int nframes, input int vpct,
                               input int rpct, input int chg_at, input int chg_w);
        logic [26:0] exp_q[$];
        logic [26:0] exp_e, popped;
        logic        acc, pop, v, r, draining, prev_eof;
        logic [23:0] rgb;
        int idx, mw, mh, frames_in, frames_out, accepts, cyc, sof_n, eol_n, eof_n, done_n, eff_h;
        idx = 0; mw = 1; mh = 1; frames_in = 0; frames_out = 0; accepts = 0; cyc = 0;
        sof_n = 0; eol_n = 0; eof_n = 0; done_n = 0; draining = 1'b0; prev_eof = 1'b0;
        eff_h = (h == 0) ? 1 : h;
        frame_width = 12'(w); frame_height = 12'(h);
        while (frames_out < nframes && cyc < 40000) begin
            total_cnt++; if (fill_level !== 5'(exp_q.size())) $display("FAIL stream_fill: got %0d want %0d", fill_level, exp_q.size()); else pass_cnt++;
            total_cnt++; if (bus.out_valid !== (exp_q.size() != 0)) $display("FAIL stream_out_valid: got %b want %b", bus.out_valid, exp_q.size() != 0); else pass_cnt++;
            total_cnt++;
            if (bus.in_ready !== (!draining && exp_q.size() < DEPTH))
                $display("FAIL stream_in_ready: got %b want %b (fill %0d)", bus.in_ready, !draining && exp_q.size() < DEPTH, exp_q.size());
            else pass_cnt++;
            total_cnt++; if (frame_done !== prev_eof) $display("FAIL stream_frame_done: got %b want %b", frame_done, prev_eof); else pass_cnt++;
            if (frame_done === 1'b1) done_n++;
            total_cnt++; if (busy !== (idx != 0 || draining)) $display("FAIL stream_busy: got %b want %b", busy, idx != 0 || draining); else pass_cnt++;
            v   = (frames_in < nframes) && (int'($urandom_range(0, 99)) < vpct);
            rgb = 24'($urandom);
            r   = int'($urandom_range(0, 99)) < rpct;
            cycle(v, rgb, r, acc, pop, popped);
            cyc++;
            prev_eof = 1'b0;
            if (pop) begin
                sof_n += int'(popped[26]); eol_n += int'(popped[25]); eof_n += int'(popped[24]);
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_pop_empty: got entry %h want no pop", popped);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (popped !== exp_e) $display("FAIL stream_data: got %h want %h", popped, exp_e);
                    else pass_cnt++;
                    if (exp_e[24]) begin
                        draining = 1'b0; frames_out++; prev_eof = 1'b1;
                    end
                end
            end
            if (acc) begin
                if (idx == 0) begin
                    mw = (frame_width == 12'd0) ? 1 : int'(frame_width);
                    mh = (frame_height == 12'd0) ? 1 : int'(frame_height);
                end
                exp_e = {idx == 0, (idx % mw) == mw - 1, idx == mw * mh - 1, rgb};
                exp_q.push_back(exp_e);
                accepts++;
                if (exp_e[24]) begin
                    draining = 1'b1; idx = 0; frames_in++;
                end else begin
                    idx++;
                end
                if (accepts == chg_at) frame_width = 12'(chg_w);
            end
        end
        total_cnt++; if (frames_out != nframes) $display("FAIL stream_timeout: got %0d frames want %0d", frames_out, nframes); else pass_cnt++;
        total_cnt++; if (frame_done !== prev_eof) $display("FAIL stream_last_done: got %b want %b", frame_done, prev_eof); else pass_cnt++;
        if (frame_done === 1'b1) done_n++;
        cycle(1'b0, 24'h0, 1'b0, acc, pop, popped);
        total_cnt++; if ({frame_done, busy} !== 2'b00) $display("FAIL stream_after_done: got %b want 00", {frame_done, busy}); else pass_cnt++;
        total_cnt++; if (sof_n != nframes) $display("FAIL stream_sof_count: got %0d want %0d", sof_n, nframes); else pass_cnt++;
        total_cnt++; if (eol_n != nframes * eff_h) $display("FAIL stream_eol_count: got %0d want %0d", eol_n, nframes * eff_h); else pass_cnt++;
        total_cnt++; if (eof_n != nframes) $display("FAIL stream_eof_count: got %0d want %0d", eof_n, nframes); else pass_cnt++;
        total_cnt++; if (done_n != nframes) $display("FAIL stream_done_count: got %0d want %0d", done_n, nframes); else pass_cnt++;
    endtask

    task automatic test_full();
        logic        acc, pop;
        logic [26:0] popped;
        logic [23:0] rgb, first_rgb;
        int          n_acc;
        frame_width = 12'd8; frame_height = 12'd8; n_acc = 0; first_rgb = 24'h0;
        for (int i = 0; i < 24; i++) begin
            rgb = 24'($urandom);
            cycle(1'b1, rgb, 1'b0, acc, pop, popped);
            if (acc) begin
                if (n_acc == 0) first_rgb = rgb;
                n_acc++;
            end
        end
        total_cnt++; if (n_acc != DEPTH) $display("FAIL full_accepts: got %0d want %0d", n_acc, DEPTH); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd16) $display("FAIL full_fill: got %0d want 16", fill_level); else pass_cnt++;
        cycle(1'b1, 24'($urandom), 1'b1, acc, pop, popped);
        total_cnt++; if ({acc, pop} !== 2'b01) $display("FAIL full_pop_handshake: got acc/pop %b want 01", {acc, pop}); else pass_cnt++;
        total_cnt++; if (popped !== {3'b100, first_rgb}) $display("FAIL full_head: got %h want %h", popped, {3'b100, first_rgb}); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd15) $display("FAIL full_fill_after_pop: got %0d want 15", fill_level); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL full_in_ready_after_pop: got %b want 1", bus.in_ready); else pass_cnt++;
        rst = 1'b1;
        cycle(1'b0, 24'h0, 1'b0, acc, pop, popped);
        rst = 1'b0;
        cycle(1'b0, 24'h0, 1'b0, acc, pop, popped);
    endtask

    task automatic test_reset_mid();
        logic        acc, pop;
        logic [26:0] popped;
        int          n_acc;
        frame_width = 12'd4; frame_height = 12'd4; n_acc = 0;
        for (int i = 0; i < 20 && n_acc < 5; i++) begin
            cycle(1'b1, 24'($urandom), 1'b0, acc, pop, popped);
            if (acc) n_acc++;
        end
        total_cnt++; if (fill_level !== 5'd5) $display("FAIL mid_fill_before: got %0d want 5", fill_level); else pass_cnt++;
        rst = 1'b1;
        cycle(1'b0, 24'h0, 1'b0, acc, pop, popped);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (fill_level !== 5'd0) $display("FAIL mid_fill: got %0d want 0", fill_level); else pass_cnt++;
        total_cnt++; if ({busy, bus.in_ready, bus.out_sof} !== 3'b000) $display("FAIL mid_status: got %b want 000", {busy, bus.in_ready, bus.out_sof}); else pass_cnt++;
        rst = 1'b0;
        cycle(1'b0, 24'h0, 1'b0, acc, pop, popped);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; frame_width = 12'd4; frame_height = 12'd2;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_rgb = 24'h0;
        test_reset();
        test_stream(4, 2, 1, 100, 100, -1, 0);
        test_full();
        test_stream(1, 1, 2, 100, 50, -1, 0);
        test_stream(0, 0, 1, 100, 100, -1, 0);
        test_reset_mid();
        test_stream(4, 4, 2, 100, 100, 5, 8);
        test_stream(640, 4, 3, 70, 70, -1, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
